// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and helpers for the reset sequencer
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ASSERT    = 3'd0,
    WAIT_LOCK = 3'd1,
    HOLD      = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage single-bit synchroniser with async active-low clear
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sh;

  // shift d through STAGES flops; clear drops the chain to zero immediately
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sh <= '0;
    end else begin
      sh <= {sh[STAGES-2:0], d};
    end
  end

  assign q = sh[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// rtl/reset_seq.sv - staggered multi-channel reset sequencer with lock and soft restart
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int CHANNELS       = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lock_i,
  input  logic                soft_req,
  output logic                soft_ack,
  output logic [CHANNELS-1:0] rst_p,
  output logic                ready
);

  localparam int CW = $clog2(max_i(HOLD_CYCLES, (CHANNELS-1)*STAGGER_CYCLES) + 1);

  logic srst_n;
  logic lock_s;

  // internal reset: asserts with rst_n, releases only after SYNC_STAGES edges
  sync_ff #(.STAGES(SYNC_STAGES)) u_srst (
    .clk   (clk),
    .clr_n (rst_n),
    .d     (1'b1),
    .q     (srst_n)
  );

  // lock is asynchronous to clk; it only counts once the internal reset is gone
  sync_ff #(.STAGES(SYNC_STAGES)) u_lock (
    .clk   (clk),
    .clr_n (srst_n),
    .d     (lock_i),
    .q     (lock_s)
  );

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CHANNELS-1:0] rst_p_q, rst_p_d;
  logic                ready_q, ready_d;
  logic                ack_q, ack_d;
  logic                lost;

  // state, counter and registered outputs; everything held in reset by srst_n
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      rst_p_q <= '1;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_p_q <= rst_p_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
    end
  end

  // next-state and output logic; lock loss outranks everything once sequencing starts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_p_d = rst_p_q;
    ready_d = ready_q;
    ack_d   = 1'b0;
    lost    = !lock_s && ((state_q == HOLD) || (state_q == RELEASE) || (state_q == RUN));

    if (lost) begin
      state_d = WAIT_LOCK;
      rst_p_d = '1;
      ready_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ASSERT: begin
          state_d = WAIT_LOCK;
          rst_p_d = '1;
          ready_d = 1'b0;
          cnt_d   = '0;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = HOLD;
            cnt_d   = '0;
          end
        end
        HOLD: begin
          cnt_d = cnt_q + CW'(1);
          if (int'(cnt_q) == HOLD_CYCLES - 1) begin
            rst_p_d[0] = 1'b0;
            cnt_d      = '0;
            if (CHANNELS == 1) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          cnt_d = cnt_q + CW'(1);
          for (int i = 1; i < CHANNELS; i++) begin
            if (int'(cnt_q) == i*STAGGER_CYCLES - 1) begin
              rst_p_d[i] = 1'b0;
            end
          end
          if (int'(cnt_q) == (CHANNELS-1)*STAGGER_CYCLES - 1) begin
            state_d = RUN;
            ready_d = 1'b1;
            cnt_d   = '0;
          end
        end
        RUN: begin
          if (soft_req) begin
            state_d = HOLD;
            rst_p_d = '1;
            ready_d = 1'b0;
            ack_d   = 1'b1;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ASSERT;
          rst_p_d = '1;
          ready_d = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign rst_p    = rst_p_q;
  assign ready    = ready_q;
  assign soft_ack = ack_q;

endmodule

// File: tb/tb_reset_seq.sv
// tb/tb_reset_seq.sv - directed self-checking bench for reset_seq
module tb_reset_seq;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst_n;
  logic       lock_i;
  logic       soft_req;
  logic       soft_ack;
  logic [2:0] rst_p;
  logic       ready;

  int checks = 0;
  int errors = 0;

  reset_seq #(
    .CHANNELS       (3),
    .SYNC_STAGES    (2),
    .HOLD_CYCLES    (16),
    .STAGGER_CYCLES (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lock_i   (lock_i),
    .soft_req (soft_req),
    .soft_ack (soft_ack),
    .rst_p    (rst_p),
    .ready    (ready)
  );

  // gated 10 ns clock so the async-reset case can be checked with no edges
  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [2:0] e_rst, input logic e_rdy, input logic e_ack);
    chk({tag, ".rst_p"}, 8'(rst_p), 8'(e_rst));
    chk({tag, ".ready"}, 8'(ready), 8'(e_rdy));
    chk({tag, ".ack"}, 8'(soft_ack), 8'(e_ack));
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    lock_i   = 1'b1;
    soft_req = 1'b0;

    // power-up with lock already present
    #50;
    outs("por_reset", 3'b111, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;                       // E0
    adv(4);  outs("por_e4", 3'b111, 1'b0, 1'b0);
    adv(1);  outs("por_T", 3'b111, 1'b0, 1'b0);      // T = E5
    adv(15); outs("por_T15", 3'b111, 1'b0, 1'b0);
    adv(1);  outs("por_T16", 3'b110, 1'b0, 1'b0);
    adv(7);  outs("por_T23", 3'b110, 1'b0, 1'b0);
    adv(1);  outs("por_T24", 3'b100, 1'b0, 1'b0);
    adv(7);  outs("por_T31", 3'b100, 1'b0, 1'b0);
    adv(1);  outs("por_T32", 3'b000, 1'b1, 1'b0);

    // lock loss in RUN for 10 cycles, then relock
    lock_i = 1'b0;
    adv(2);  outs("loss_e2", 3'b000, 1'b1, 1'b0);
    adv(1);  outs("loss_e3", 3'b111, 1'b0, 1'b0);
    adv(7);  outs("loss_e10", 3'b111, 1'b0, 1'b0);
    lock_i = 1'b1;                      // R0, T = R3
    adv(18); outs("relock_T15", 3'b111, 1'b0, 1'b0);
    adv(1);  outs("relock_T16", 3'b110, 1'b0, 1'b0);
    adv(8);  outs("relock_T24", 3'b100, 1'b0, 1'b0);
    adv(8);  outs("relock_T32", 3'b000, 1'b1, 1'b0);

    // soft request in RUN, second request during HOLD is ignored
    soft_req = 1'b1;
    adv(1);  outs("soft_S", 3'b111, 1'b0, 1'b1);
    soft_req = 1'b0;
    adv(1);  outs("soft_S1", 3'b111, 1'b0, 1'b0);
    adv(3);
    soft_req = 1'b1;
    adv(1);  outs("soft_hold_req", 3'b111, 1'b0, 1'b0);
    soft_req = 1'b0;
    adv(10); outs("soft_S15", 3'b111, 1'b0, 1'b0);
    adv(1);  outs("soft_S16", 3'b110, 1'b0, 1'b0);
    adv(8);  outs("soft_S24", 3'b100, 1'b0, 1'b0);
    adv(8);  outs("soft_S32", 3'b000, 1'b1, 1'b0);

    // rst_n asserted mid-RELEASE with the clock stopped
    soft_req = 1'b1;
    adv(1);  outs("soft2_S", 3'b111, 1'b0, 1'b1);
    soft_req = 1'b0;
    adv(16); outs("soft2_S16", 3'b110, 1'b0, 1'b0);
    clk_en = 1'b0;
    #2;
    rst_n  = 1'b0;
    lock_i = 1'b0;
    #1;      outs("async_rst", 3'b111, 1'b0, 1'b0);
    #20;     outs("async_rst_hold", 3'b111, 1'b0, 1'b0);
    clk_en = 1'b1;
    adv(3);  outs("rst_clocked", 3'b111, 1'b0, 1'b0);
    rst_n = 1'b1;                       // E0, lock still low
    adv(10); outs("nolock_e10", 3'b111, 1'b0, 1'b0);

    // relock, then a 5-cycle lock glitch in HOLD restarts the hold count
    lock_i = 1'b1;                      // L0, first HOLD entry at L3
    adv(8);  outs("glitch_L8", 3'b111, 1'b0, 1'b0);
    lock_i = 1'b0;
    adv(5);
    lock_i = 1'b1;                      // HOLD re-entered at L16
    adv(6);  outs("glitch_L19", 3'b111, 1'b0, 1'b0);
    adv(12); outs("glitch_L31", 3'b111, 1'b0, 1'b0);
    adv(1);  outs("glitch_L32", 3'b110, 1'b0, 1'b0);
    adv(8);  outs("glitch_L40", 3'b100, 1'b0, 1'b0);
    adv(8);  outs("glitch_L48", 3'b000, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_seq.md
# reset_seq

Parametrised reset sequencer replacing the single-output power-on reset generator. It synchronises the board reset and PLL lock, holds all downstream domains in reset for a programmable time, then releases CHANNELS active-high resets in staggered order. It re-runs the sequence on lock loss or on a software request, and sits at the top level between the clock/PLL and every game-logic block (VGA timing, paddles, ball, score).

## Interface
- CHANNELS, 3: number of reset outputs; ≥1.
- SYNC_STAGES, 2: synchroniser depth for rst_n deassertion and lock_i; ≥2.
- HOLD_CYCLES, 16: cycles all outputs stay asserted after lock before channel 0 releases; ≥1.
- STAGGER_CYCLES, 8: cycles between successive channel releases; ≥1.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset; assertion acts immediately, deassertion is synchronised internally.
- lock_i  in  1  PLL lock, asynchronous to clk.
- soft_req  in  1  software reset request, sampled each clk.
- soft_ack  out  1  one-cycle acknowledge of an accepted soft_req.
- rst_p  out  CHANNELS  active-high resets; bit i released i*STAGGER_CYCLES after bit 0.
- ready  out  1  high when all channels are released (state RUN).

## Operation
- rst_n low: asynchronously rst_p = all ones, ready = 0, soft_ack = 0, state ASSERT, counters 0, synchronisers cleared. No clock needed.
- Internal reset (srst_n) = rst_n through SYNC_STAGES flops: asynchronous assert, synchronous deassert. All FSM flops use srst_n.
- lock_s = lock_i through SYNC_STAGES flops, cleared by srst_n.
- States: ASSERT, WAIT_LOCK, HOLD, RELEASE, RUN.
  - ASSERT -> WAIT_LOCK on the first edge with srst_n high.
  - WAIT_LOCK -> HOLD when lock_s = 1; cnt <= 0.
  - HOLD: cnt increments; on cnt == HOLD_CYCLES-1 go to RELEASE (to RUN if CHANNELS == 1) and clear rst_p[0]; cnt <= 0.
  - RELEASE: cnt increments; rst_p[i] clears when cnt reaches i*STAGGER_CYCLES-1; on releasing bit CHANNELS-1 go to RUN and set ready.
  - RUN: hold. soft_req = 1 goes to HOLD with rst_p = all ones, ready = 0, soft_ack = 1 for exactly one cycle, cnt <= 0.
- Lock loss (lock_s = 0) in HOLD, RELEASE or RUN: rst_p = all ones, ready = 0, go to WAIT_LOCK. Lock loss has priority over soft_req.
- soft_req outside RUN is ignored, with no soft_ack. A level held high re-triggers each time RUN is reached.
- Released channels never re-assert individually. Any re-assertion is all-ones.
- Counter width is $clog2(max(HOLD_CYCLES, (CHANNELS-1)*STAGGER_CYCLES)+1).
- All outputs are registered.

## Timing
- Let T be the edge on which the FSM enters HOLD.
- rst_p[i] falls at edge T + HOLD_CYCLES + i*STAGGER_CYCLES.
- ready rises on the same edge as the last channel falls.
- Lock rise to T: SYNC_STAGES+1 edges. Lock fall to all-ones rst_p: SYNC_STAGES+1 edges.
- rst_n deassertion to ASSERT exit: SYNC_STAGES+1 edges.
- soft_req sampled at edge S: soft_ack and all-ones rst_p registered at S, S = T for the re-sequence.

## Structure
- reset_seq_pkg holds the state enum (state_t).
- One sub-module, sync_ff: SYNC_STAGES-deep single-bit synchroniser with async active-low clear. It is instantiated twice: with D = 1 to produce srst_n, and with D = lock_i.

## Test plan
Defaults: CHANNELS=3, HOLD=16, STAGGER=8, SYNC=2; 10 ns clk.
- Power-up: rst_n low 50 ns, lock_i high -> rst_p = 3'b111 throughout reset; bits fall at T+16, T+24, T+32; ready rises at T+32.
- lock_i low until 300 ns, then high -> rst_p stays 3'b111 and ready stays 0 before lock; sequence timing matches relative to T after lock.
- Lock loss in RUN: lock_i low for 10 cycles -> rst_p = 3'b111 and ready = 0 within 3 edges; after relock, full sequence with same offsets.
- soft_req pulse in RUN -> soft_ack high exactly 1 cycle, rst_p = 3'b111, releases at S+16/S+24/S+32. soft_req pulse during HOLD -> no soft_ack, timing unchanged.
- rst_n low mid-RELEASE (rst_p = 3'b110) -> rst_p = 3'b111 and ready = 0 with clock stopped; after deassert, full sequence restarts.
- Lock glitch of 5 cycles during HOLD -> return to WAIT_LOCK; HOLD count restarts from 0 (no partial credit).
